// File: rtl/dm_store_buffer.sv
// Store buffer between MEM-stage store/load logic and a word-wide data memory.
// Latency: a store accepted at cycle N drains at N+1 if it is the head and no load is served; loads are combinational.
// Backpressure: st_ready drops when full or flushing; ld_stall holds a load when full (or, without STB_FWD_EN, on a pending match).
// Optional feature macro: STB_FWD_EN (pending-store forwarding into load data).
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [31:0] dm_addr,
    input  logic [31:0] dm_rd,
    output logic        dm_we,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [29:0]      q_addr [DEPTH];
    logic [3:0]       q_be   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [31:0]      q_pc   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic        full;
    logic        empty;
    logic        enq;
    logic        load_go;
    logic        drain;
    logic [3:0]  st_be;
    logic [31:0] st_lane;
    logic [31:0] head_mask;
    logic        unused_bits;

    // Loads address whole words; the byte offset selects nothing here.
    assign unused_bits = ^ld_addr[1:0];

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign st_ready = !reset && !full && !flush_req;
    assign enq      = st_valid && st_ready;

    // Byte enables and lane replication so the entry can be merged without shifting later.
    always_comb begin
        st_be   = 4'b1111;
        st_lane = st_data;
        case (st_op)
            2'b01: begin
                st_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                st_lane = {2{st_data[15:0]}};
            end
            2'b10: begin
                st_be   = 4'b0001 << st_addr[1:0];
                st_lane = {4{st_data[7:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_lane = st_data;
            end
        endcase
    end

`ifdef STB_FWD_EN
    logic [31:0] fwd_word;

    // Overlay pending bytes oldest to youngest so the youngest store wins each lane.
    always_comb begin
        fwd_word = dm_rd;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count) && (q_addr[idx] == ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (q_be[idx][b]) begin
                        fwd_word[8*b +: 8] = q_data[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign ld_stall = !reset && ld_valid && full;
    assign ld_data  = fwd_word;
`else
    logic hit;

    // Any pending entry for the load's word holds the load until it has drained.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count) && (q_addr[idx] == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall = !reset && ld_valid && (full || hit);
    assign ld_data  = dm_rd;
`endif

    // A serviced load owns the port; otherwise the head drains. Full queue forces drain.
    assign load_go = ld_valid && !ld_stall && !full;
    assign drain   = !reset && !load_go && !empty;

    assign head_mask = {{8{q_be[head][3]}}, {8{q_be[head][2]}},
                        {8{q_be[head][1]}}, {8{q_be[head][0]}}};

    assign dm_we      = drain;
    assign dm_addr    = drain ? {q_addr[head], 2'b00} : {ld_addr[31:2], 2'b00};
    assign dm_wd      = (dm_rd & ~head_mask) | (q_data[head] & head_mask);
    assign dm_pc      = q_pc[head];
    assign flush_done = reset || empty;

    // Queue pointers and occupancy; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count + (PTR_W + 1)'(enq) - (PTR_W + 1)'(drain);
        end
    end

    // Entry payload; only the tail slot is written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            q_addr[tail] <= st_addr[31:2];
            q_be[tail]   <= st_be;
            q_data[tail] <= st_lane;
            q_pc[tail]   <= st_pc;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] dm_addr;
    logic [31:0] dm_rd;
    logic        dm_we;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
        .flush_req(flush_req), .flush_done(flush_done),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_we(dm_we), .dm_wd(dm_wd), .dm_pc(dm_pc)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT, and the reference memory of the model.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    assign dm_rd = mem[dm_addr[7:2]];

    typedef struct packed {
        logic [29:0]     waddr;
        logic [3:0]      be;
        logic [3:0][7:0] b;
        logic [31:0]     pc;
    } ent_t;

    ent_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Which bytes a store writes and with what value, straight from the op rules.
    function automatic ent_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] pc);
        ent_t e;
        e.waddr = a[31:2];
        e.pc    = pc;
        e.be    = 4'b0000;
        e.b     = '0;
        case (op)
            2'b01: begin
                e.be[{a[1], 1'b0}] = 1'b1; e.b[{a[1], 1'b0}] = d[7:0];
                e.be[{a[1], 1'b1}] = 1'b1; e.b[{a[1], 1'b1}] = d[15:8];
            end
            2'b10: begin
                e.be[a[1:0]] = 1'b1; e.b[a[1:0]] = d[7:0];
            end
            default: begin
                e.be = 4'b1111; e.b = d;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] w, input ent_t e);
        logic [31:0] r;
        r = w;
        for (int l = 0; l < 4; l++) begin
            if (e.be[l]) r[8*l +: 8] = e.b[l];
        end
        return r;
    endfunction

    // One clock: compare all outputs to the model, then advance model and memory.
    task automatic step();
        int n;
        logic match, stall, ld_ok, drn, cap_we;
        logic [31:0] w, cap_addr, cap_wd;
        #1;
        n = q.size();
        match = 1'b0;
        foreach (q[i]) if (q[i].waddr == ld_addr[31:2]) match = 1'b1;
`ifdef STB_FWD_EN
        stall = ld_valid && (n == 4);
`else
        stall = ld_valid && ((n == 4) || match);
`endif
        if (reset) stall = 1'b0;
        ld_ok = !reset && ld_valid && !stall;
        drn   = !reset && !ld_ok && (n != 0);
        chk1("st_ready", st_ready, !reset && (n != 4) && !flush_req);
        chk1("ld_stall", ld_stall, stall);
        chk1("dm_we", dm_we, drn);
        chk1("flush_done", flush_done, reset || (n == 0));
        if (drn) begin
            w = apply(ref_mem[q[0].waddr[5:0]], q[0]);
            chk("dm_addr_drain", dm_addr, {q[0].waddr, 2'b00});
            chk("dm_wd", dm_wd, w);
            chk("dm_pc", dm_pc, q[0].pc);
        end else begin
            chk("dm_addr_load", dm_addr, {ld_addr[31:2], 2'b00});
        end
        if (ld_ok) begin
            w = ref_mem[ld_addr[7:2]];
            foreach (q[i]) if (q[i].waddr == ld_addr[31:2]) w = apply(w, q[i]);
            chk("ld_data", ld_data, w);
        end
        cap_we = dm_we; cap_addr = dm_addr; cap_wd = dm_wd;
        @(posedge clk);
        if (cap_we) mem[cap_addr[7:2]] = cap_wd;
        if (reset) begin
            q.delete();
        end else begin
            if (drn) begin
                ref_mem[q[0].waddr[5:0]] = apply(ref_mem[q[0].waddr[5:0]], q[0]);
                void'(q.pop_front());
            end
            if (st_valid && (n != 4) && !flush_req) q.push_back(mk(st_op, st_addr, st_data, st_pc));
        end
        @(negedge clk);
    endtask

    task automatic set_st(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d; st_pc = pc;
    endtask

    task automatic drain_all();
        int c;
        st_valid = 1'b0; ld_valid = 1'b0; flush_req = 1'b0; reset = 1'b0;
        c = 0;
        while (q.size() != 0 && c < 20) begin
            step();
            c++;
        end
        #1;
        chk1("drain_done", flush_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] t3_dat [10];
        int acc, cyc;
        reset = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0; st_pc = '0;
        ld_valid = 1'b0; ld_addr = '0; flush_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        #1;
        chk1("rst_st_ready", st_ready, 1'b0);
        chk1("rst_dm_we", dm_we, 1'b0);
        chk1("rst_ld_stall", ld_stall, 1'b0);
        chk1("rst_flush_done", flush_done, 1'b1);
        step();
        reset = 1'b0;

        // Single word store drains the following cycle.
        set_st(2'b00, 32'h10, 32'hDEADBEEF, 32'h400);
        step();
        st_valid = 1'b0;
        #1;
        chk1("t1_we", dm_we, 1'b1);
        chk("t1_addr", dm_addr, 32'h10);
        chk("t1_wd", dm_wd, 32'hDEADBEEF);
        chk("t1_pc", dm_pc, 32'h400);
        step();
        #1;
        chk1("t1_done", flush_done, 1'b1);
        step();

        // Byte then half merge into an existing word.
        mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        set_st(2'b10, 32'h21, 32'h000000AA, 32'h404);
        step();
        set_st(2'b01, 32'h22, 32'h00005566, 32'h408);
        #1;
        chk1("t2_we0", dm_we, 1'b1);
        chk("t2_wd0", dm_wd, 32'h1122AA44);
        step();
        st_valid = 1'b0;
        #1;
        chk("t2_wd1", dm_wd, 32'h5566AA44);
        step();
        step();

        // Fill with loads held high: full forces a drain, pointers wrap over 10 stores.
        ld_valid = 1'b1; ld_addr = 32'h80;
        acc = 0; cyc = 0;
        while (acc < 10 && cyc < 60) begin
            t3_dat[acc] = $urandom;
            set_st(2'b00, 32'h40 + 32'(4 * acc), t3_dat[acc], 32'h1000 + 32'(acc));
            #1;
            if (q.size() == 4) begin
                chk1("t3_full_rdy", st_ready, 1'b0);
                chk1("t3_full_stall", ld_stall, 1'b1);
                chk1("t3_full_drain", dm_we, 1'b1);
            end else if (q.size() == 3) begin
                chk1("t3_cnt3_load", ld_stall, 1'b0);
            end
            if (q.size() != 4) acc++;
            step();
            cyc++;
        end
        drain_all();
        for (int i = 0; i < 10; i++) chk("t3_mem", mem[16 + i], t3_dat[i]);

        // Two bytes to the same lane, then a load of that word.
        mem[12] = 32'h0; ref_mem[12] = 32'h0;
        ld_valid = 1'b1; ld_addr = 32'h80;
        set_st(2'b10, 32'h33, 32'h7F, 32'h500);
        step();
        set_st(2'b10, 32'h33, 32'h80, 32'h504);
        step();
        st_valid = 1'b0; ld_addr = 32'h30;
        #1;
`ifdef STB_FWD_EN
        chk1("t4_stall", ld_stall, 1'b0);
        chk("t4_data", ld_data, 32'h80000000);
`else
        cyc = 0;
        while (ld_stall && cyc < 6) begin
            step();
            cyc++;
            #1;
        end
        chk("t4_stall_cycles", cyc, 2);
        chk1("t4_stall", ld_stall, 1'b0);
        chk("t4_data", ld_data, 32'h80000000);
`endif
        step();
        drain_all();

        // Reset with three pending entries discards them.
        ld_valid = 1'b1; ld_addr = 32'h80;
        v = mem[20];
        for (int i = 0; i < 3; i++) begin
            set_st(2'b00, 32'h50 + 32'(4 * i), 32'hFFFFFFFF, 32'h600);
            step();
        end
        st_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
        #1;
        chk1("t5_we_rst", dm_we, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk1("t5_we_after", dm_we, 1'b0);
        chk1("t5_done", flush_done, 1'b1);
        step();
        chk("t5_mem_kept", mem[20], v);

        // Flush with two pending blocks stores and completes two cycles later.
        ld_valid = 1'b1; ld_addr = 32'h80;
        set_st(2'b00, 32'h60, 32'hCAFE0001, 32'h700);
        step();
        set_st(2'b00, 32'h64, 32'hCAFE0002, 32'h704);
        step();
        ld_valid = 1'b0; flush_req = 1'b1;
        set_st(2'b00, 32'h68, 32'hCAFE0003, 32'h708);
        #1;
        chk1("t6_rdy", st_ready, 1'b0);
        chk1("t6_done0", flush_done, 1'b0);
        step();
        #1;
        chk1("t6_done1", flush_done, 1'b0);
        step();
        #1;
        chk1("t6_done2", flush_done, 1'b1);
        step();
        flush_req = 1'b0; st_valid = 1'b0;

        // Random traffic over a small address window to provoke matches.
        for (int c = 0; c < 500; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            st_valid  = 1'($urandom_range(0, 1));
            st_op     = 2'($urandom_range(0, 3));
            st_addr   = 32'($urandom_range(0, 63));
            st_data   = $urandom;
            st_pc     = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 40);
            ld_addr   = 32'($urandom_range(0, 63));
            flush_req = ($urandom_range(0, 99) < 8);
            step();
        end
        drain_all();
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
